// File: rtl/vc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vc_pkg: constants and width helper shared by the credit converters|
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package vc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CREDIT_NUM = 2;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int credit_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | credit_counter: saturating credit counter, 0..MAX, resets to MAX  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module credit_counter
  import vc_pkg::*;
#(
  parameter int MAX = DEFAULT_CREDIT_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec,
  input  logic                     inc,
  output logic [credit_w(MAX)-1:0] cnt,
  output logic                     zero,
  output logic                     full,
  output logic                     ovf
);

  localparam int CNT_W = credit_w(MAX);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  assign zero = (cnt == '0);
  assign full = (cnt == MAX_V);
  // A returned credit with nowhere to go: the counter holds at MAX.
  assign ovf  = inc && !dec && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= MAX_V;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vr_vc_converter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vr_vc_converter: valid/ready to valid/credit stream transmitter.  |
// | Optional macro VR_VC_CREDIT_CHECK_EN: sticky err_o + assertions.  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module vr_vc_converter
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CREDIT_NUM = DEFAULT_CREDIT_NUM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_data_i,
  input  logic                            s_valid_i,
  output logic                            s_ready_o,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  output logic                            m_valid_o,
  input  logic                            m_credit_i,
  output logic [credit_w(CREDIT_NUM)-1:0] credit_cnt_o,
  output logic                            idle_o,
  output logic                            err_o
);

  logic accept;
  logic zero;
  logic full;
  logic ovf;

  credit_counter #(
    .MAX (CREDIT_NUM)
  ) u_credit_counter (
    .clk  (clk),
    .rst  (rst),
    .dec  (accept),
    .inc  (m_credit_i),
    .cnt  (credit_cnt_o),
    .zero (zero),
    .full (full),
    .ovf  (ovf)
  );

  // Ready depends on the counter register alone, never on valid or credit.
  assign s_ready_o = !zero;
  assign idle_o    = full;
  assign accept    = s_valid_i && s_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
    end else begin
      m_valid_o <= accept;
      if (accept) begin
        m_data_o <= s_data_i;
      end
    end
  end

`ifdef VR_VC_CREDIT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (ovf) begin
      err_o <= 1'b1;
    end
  end

  generate
    if (CREDIT_NUM < 1) begin : g_bad_credit_num
      $error("vr_vc_converter: CREDIT_NUM must be at least 1");
    end
  endgenerate

  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !ovf)
    else $error("vr_vc_converter: credit overflow");

  a_data_stable : assert property (@(posedge clk) disable iff (rst)
                                   (s_valid_i && !s_ready_o) |=> $stable(s_data_i))
    else $error("vr_vc_converter: s_data_i changed while stalled");
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign err_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vr_vc_converter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vr_vc_converter: directed self-checking bench, CREDIT_NUM = 2  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_vr_vc_converter;

  localparam int DW = 8;
  localparam int CN = 2;

`ifdef VR_VC_CREDIT_CHECK_EN
  localparam logic ERR_ON_OVF = 1'b1;
`else
  localparam logic ERR_ON_OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_credit;
  logic [1:0]    credit_cnt;
  logic          idle;
  logic          err;

  int checks = 0;
  int errors = 0;

  vr_vc_converter #(
    .DATA_WIDTH (DW),
    .CREDIT_NUM (CN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_credit_i   (m_credit),
    .credit_cnt_o (credit_cnt),
    .idle_o       (idle),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] c, input logic r);
    check_val({tag, ".m_valid"}, 32'(m_valid), 32'(v));
    check_val({tag, ".m_data"}, 32'(m_data), 32'(d));
    check_val({tag, ".cnt"}, 32'(credit_cnt), 32'(c));
    check_val({tag, ".ready"}, 32'(s_ready), 32'(r));
  endtask

  initial begin
    rst      = 1'b1;
    s_data   = '0;
    s_valid  = 1'b0;
    m_credit = 1'b0;
    #2;
    check_out("rst_async", 1'b0, 8'h00, 2'd2, 1'b1);
    check_val("rst_async.idle", 32'(idle), 32'd1);
    check_val("rst_async.err", 32'(err), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_out("rst_idle", 1'b0, 8'h00, 2'd2, 1'b1);
    check_val("rst_idle.idle", 32'(idle), 32'd1);

    // Back-to-back beats with no credit returned.
    s_valid = 1'b1;
    s_data  = 8'hAA;
    tick();
    check_out("b2b_aa", 1'b1, 8'hAA, 2'd1, 1'b1);
    check_val("b2b_aa.idle", 32'(idle), 32'd0);
    s_data = 8'hBB;
    tick();
    check_out("b2b_bb", 1'b1, 8'hBB, 2'd0, 1'b0);
    s_data = 8'hCC;
    tick();
    check_out("stall_cc0", 1'b0, 8'hBB, 2'd0, 1'b0);
    tick();
    check_out("stall_cc1", 1'b0, 8'hBB, 2'd0, 1'b0);

    // One credit releases exactly one held beat.
    m_credit = 1'b1;
    tick();
    check_out("credit_rel", 1'b0, 8'hBB, 2'd1, 1'b1);
    m_credit = 1'b0;
    tick();
    check_out("emit_cc", 1'b1, 8'hCC, 2'd0, 1'b0);
    s_valid = 1'b0;
    tick();
    check_out("after_cc", 1'b0, 8'hCC, 2'd0, 1'b0);

    // Bring count to 1, then accept with a simultaneous credit.
    m_credit = 1'b1;
    tick();
    check_out("cnt_one", 1'b0, 8'hCC, 2'd1, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'h80;
    tick();
    check_out("simul_80", 1'b1, 8'h80, 2'd1, 1'b1);

    // Credit looped back one cycle after each beat sustains full rate.
    for (int i = 0; i < 8; i++) begin
      s_data   = 8'(8'h10 + i);
      m_credit = m_valid;
      tick();
      check_out($sformatf("stream_%0d", i), 1'b1, 8'(8'h10 + i), 2'd1, 1'b1);
    end
    s_valid  = 1'b0;
    m_credit = m_valid;
    tick();
    check_out("stream_drain", 1'b0, 8'h17, 2'd2, 1'b1);
    check_val("stream_drain.idle", 32'(idle), 32'd1);

    // Credit returned while already full.
    m_credit = 1'b1;
    tick();
    m_credit = 1'b0;
    check_val("ovf.cnt", 32'(credit_cnt), 32'd2);
    check_val("ovf.err", 32'(err), 32'(ERR_ON_OVF));
    tick();
    tick();
    check_val("ovf_sticky.cnt", 32'(credit_cnt), 32'd2);
    check_val("ovf_sticky.err", 32'(err), 32'(ERR_ON_OVF));

    // Drain credits to zero, then reset while a beat is on the wire.
    s_valid = 1'b1;
    s_data  = 8'h01;
    tick();
    s_data = 8'h02;
    tick();
    check_out("pre_rst", 1'b1, 8'h02, 2'd0, 1'b0);
    rst      = 1'b1;
    m_credit = 1'b1;
    #1;
    check_out("mid_rst", 1'b0, 8'h00, 2'd2, 1'b1);
    check_val("mid_rst.idle", 32'(idle), 32'd1);
    check_val("mid_rst.err", 32'(err), 32'd0);
    tick();
    check_val("rst_credit_ignored.cnt", 32'(credit_cnt), 32'd2);
    rst      = 1'b0;
    m_credit = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h50;
    tick();
    check_out("post_rst_50", 1'b0, 8'h00, 2'd2, 1'b1);
    tick();
    check_out("post_rst_50b", 1'b0, 8'h00, 2'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vr_vc_converter.md
# vr_vc_converter

Converts a valid/ready stream into a valid/credit stream. It is the transmitting end that pairs with `vc_vr_converter` across a credit-based link. A credit counter, initialised to `CREDIT_NUM`, gates acceptance on the valid/ready side. Each accepted beat is driven onto the credit side as a single-cycle registered pulse, and each returned credit pulse restores one slot.

## Interface
- `DATA_WIDTH`, 8: payload width in bits.
- `CREDIT_NUM`, 2: credits granted by the downstream receiver; must be ≥ 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_data_i`  in  DATA_WIDTH  upstream payload.
- `s_valid_i`  in  1  upstream beat valid.
- `s_ready_o`  out  1  upstream may transfer; transfer occurs when `s_valid_i && s_ready_o` at a rising edge.
- `m_data_o`  out  DATA_WIDTH  payload toward the receiver; registered.
- `m_valid_o`  out  1  one-cycle pulse per beat; registered.
- `m_credit_i`  in  1  one-cycle pulse per credit returned by the receiver.
- `credit_cnt_o`  out  $clog2(CREDIT_NUM+1)  current available credits.
- `idle_o`  out  1  high when `credit_cnt_o == CREDIT_NUM`, meaning all beats are drained.
- `err_o`  out  1  sticky credit-overflow flag.

## Operation
- Reset values:
  - `credit_cnt_o` = CREDIT_NUM
  - `m_valid_o` = 0
  - `m_data_o` = 0
  - `err_o` = 0
  - `s_ready_o` = 1
  - `idle_o` = 1
- `s_ready_o` = (credit count != 0). It is decoded from the counter register only. There is no combinational path from `s_valid_i` or `m_credit_i` to `s_ready_o`.
- Accept (`s_valid_i && s_ready_o`):
  - `m_data_o` <= `s_data_i`
  - `m_valid_o` <= 1
  - count decrements.
- No accept:
  - `m_valid_o` <= 0
  - `m_data_o` holds its last value.
- `m_credit_i` high: count increments.
- Simultaneous accept and credit: count unchanged; a beat is still emitted.
- Empty (count = 0): `s_ready_o` = 0. Upstream must hold `s_valid_i`/`s_data_i` stable per valid/ready rules. The block never drops or duplicates a beat.
- Full (count = CREDIT_NUM) with credit return and no accept: overflow. The count saturates at CREDIT_NUM and the overflow is handled per Configuration.
- Arithmetic: the counter is unsigned and never wraps. Underflow is impossible because accept requires count != 0.
- Reset mid-operation:
  - The count returns to CREDIT_NUM and `m_valid_o` drops in the same cycle (asynchronous).
  - In-flight beats and credits are discarded.
  - The receiver must be reset in the same window.
  - `m_credit_i` is ignored while `rst` is high.

## Timing
- Latency: a beat accepted at edge N appears on `m_valid_o`/`m_data_o` during cycle N→N+1, for exactly one cycle.
- Credit loop: a credit sampled at edge N raises `s_ready_o` from edge N onward, i.e. it is usable at edge N+1.
- Throughput: one beat per cycle while credits are available. Sustained full rate requires the round-trip credit latency to be ≤ CREDIT_NUM cycles.
- `credit_cnt_o`, `idle_o` and `err_o` are all registered or register-decoded.

## Configuration
- Macro `VR_VC_CREDIT_CHECK_EN`.
- Defined:
  - Overflow sets `err_o` at the next edge; it is sticky until `rst`.
  - Simulation assertions check three conditions:
    - no overflow;
    - `s_data_i` is stable while `s_valid_i && !s_ready_o`;
    - `CREDIT_NUM` ≥ 1 at elaboration.
- Undefined:
  - `err_o` is tied to 0 and no assertions are compiled.
  - Saturation of the counter is unchanged.

## Structure
- Shared package `vc_pkg` holds:
  - the function `credit_w(n)` = $clog2(n+1);
  - the default `DATA_WIDTH` and `CREDIT_NUM` constants;
  - these are shared with `vc_vr_converter`.
- Sub-module `credit_counter`:
  - inputs: `dec`, `inc`;
  - parameter `MAX`;
  - outputs: `cnt`, `zero`, `full`, `ovf`;
  - saturating behaviour.
- The top level holds only the output register and the error flag.

## Test plan
CREDIT_NUM=2 for all scenarios.
- Reset: assert `rst` → `credit_cnt_o`=2, `s_ready_o`=1, `idle_o`=1, `m_valid_o`=0, `err_o`=0.
- Back-to-back with no credit return: send 0xAA then 0xBB → `m_data_o` shows 0xAA then 0xBB with one-cycle `m_valid_o` pulses. Then `s_ready_o`=0 and the count is 0. A held 0xCC is not emitted.
- Credit release: one `m_credit_i` pulse → `s_ready_o`=1 on the next cycle, 0xCC is emitted once, and the count returns to 0.
- Simultaneous: at count=1, accept 0x80 while `m_credit_i`=1 → count stays 1 and 0x80 is emitted. With a credit pulse looped back one cycle after each `m_valid_o`, the stream 0x10..0x17 passes at one beat per cycle.
- Overflow: at count=2, pulse `m_credit_i`. With the macro defined, `err_o`=1 stays sticky and the count stays 2. Without it, `err_o`=0 and the count stays 2.
- Mid-operation reset: at count=0, with `m_valid_o` high, assert `rst` → outputs immediately go to their reset values and the count is 2. An 0x50 presented with `s_valid_i`=0 afterwards produces no `m_valid_o`.
